// File: rtl/pe_operand_feeder_if.sv
// Handshake bundle for pe_operand_feeder: start/config, weight and ifmap write
// streams, PE operand outputs and status. master = driver side, slave = feeder.
interface pe_operand_feeder_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [7:0]        kernel_size;
    logic [7:0]        ifmap_len;
    logic              w_wr_valid;
    logic              w_wr_ready;
    logic [DATA_W-1:0] w_wr_data;
    logic              if_wr_valid;
    logic              if_wr_ready;
    logic [DATA_W-1:0] if_wr_data;
    logic              pe_en;
    logic              pe_op_valid;
    logic [DATA_W-1:0] pe_weight;
    logic [DATA_W-1:0] pe_ifmap;
    logic [7:0]        pe_win_idx;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, kernel_size, ifmap_len,
        output w_wr_valid, w_wr_data, if_wr_valid, if_wr_data,
        input  w_wr_ready, if_wr_ready,
        input  pe_en, pe_op_valid, pe_weight, pe_ifmap, pe_win_idx,
        input  busy, done, err
    );

    modport slave (
        input  start, kernel_size, ifmap_len,
        input  w_wr_valid, w_wr_data, if_wr_valid, if_wr_data,
        output w_wr_ready, if_wr_ready,
        output pe_en, pe_op_valid, pe_weight, pe_ifmap, pe_win_idx,
        output busy, done, err
    );
endinterface

// File: rtl/pe_operand_feeder.sv
// Loads a kernel row and an ifmap row, then drives the PE controller's en and
// streams weight/ifmap pairs per stride-1 window. Ports: clk, rst, io (slave).
module pe_operand_feeder #(
    parameter int DATA_W = 8,
    parameter int MAX_K  = 16,
    parameter int MAX_IF = 64
) (
    input logic                 clk,
    input logic                 rst,
    pe_operand_feeder_if.slave  io
);
    localparam int KW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int IW = (MAX_IF > 1) ? $clog2(MAX_IF) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_IPSUM, S_OP, S_OPSUM
    } state_t;

    state_t state_q, state_d;
    logic [7:0] k_q, k_d, l_q, l_d;
    logic [7:0] w_cnt_q, w_cnt_d, if_cnt_q, if_cnt_d;
    logic [7:0] win_q, win_d, j_q, j_d;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       en_q, en_d, opv_q, opv_d;
    logic       w_rdy_q, w_rdy_d, if_rdy_q, if_rdy_d;
    logic [DATA_W-1:0] wt_q, wt_d, ifm_q, ifm_d;

    logic [DATA_W-1:0] w_mem  [MAX_K];
    logic [DATA_W-1:0] if_mem [MAX_IF];

    logic w_fire, if_fire, start_ok;
    logic [7:0] rd_sum;

    assign w_fire  = io.w_wr_valid  & w_rdy_q;
    assign if_fire = io.if_wr_valid & if_rdy_q;

    assign start_ok = (io.kernel_size != 8'd0)
                   && (io.kernel_size <= 8'(MAX_K))
                   && (io.kernel_size <= io.ifmap_len)
                   && (io.ifmap_len <= 8'(MAX_IF));

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        l_d      = l_q;
        w_cnt_d  = w_cnt_q;
        if_cnt_d = if_cnt_q;
        win_d    = win_q;
        j_d      = j_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        if (w_fire)  w_cnt_d  = w_cnt_q + 8'd1;
        if (if_fire) if_cnt_d = if_cnt_q + 8'd1;

        unique case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    if (start_ok) begin
                        k_d      = io.kernel_size;
                        l_d      = io.ifmap_len;
                        w_cnt_d  = 8'd0;
                        if_cnt_d = 8'd0;
                        win_d    = 8'd0;
                        j_d      = 8'd0;
                        state_d  = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // Use post-write counts so ARM follows the last write directly.
                if (w_cnt_d == k_q && if_cnt_d == l_q) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_IPSUM;
            end
            S_IPSUM: begin
                j_d     = 8'd0;
                state_d = S_OP;
            end
            S_OP: begin
                if (j_q == k_q - 8'd1) state_d = S_OPSUM;
                else                   j_d = j_q + 8'd1;
            end
            S_OPSUM: begin
                // Last window when w + K == L, i.e. w == N-1.
                if (win_q + k_q == l_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    win_d   = win_q + 8'd1;
                    state_d = S_IPSUM;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from next-state values, which puts the
        // scratchpad read one cycle ahead of the OP cycle it belongs to.
        busy_d   = (state_d != S_IDLE);
        opv_d    = (state_d == S_OP);
        en_d     = (state_d == S_ARM)
                || (state_d == S_OPSUM && (win_d + k_d) != l_d);
        w_rdy_d  = (state_d == S_LOAD) && (w_cnt_d < k_d);
        if_rdy_d = (state_d == S_LOAD) && (if_cnt_d < l_d);
        rd_sum   = win_d + j_d;
        wt_d     = '0;
        ifm_d    = '0;
        if (state_d == S_OP) begin
            wt_d  = w_mem[KW'(j_d)];
            ifm_d = if_mem[IW'(rd_sum)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            l_q      <= '0;
            w_cnt_q  <= '0;
            if_cnt_q <= '0;
            win_q    <= '0;
            j_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            en_q     <= 1'b0;
            opv_q    <= 1'b0;
            w_rdy_q  <= 1'b0;
            if_rdy_q <= 1'b0;
            wt_q     <= '0;
            ifm_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            l_q      <= l_d;
            w_cnt_q  <= w_cnt_d;
            if_cnt_q <= if_cnt_d;
            win_q    <= win_d;
            j_q      <= j_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            en_q     <= en_d;
            opv_q    <= opv_d;
            w_rdy_q  <= w_rdy_d;
            if_rdy_q <= if_rdy_d;
            wt_q     <= wt_d;
            ifm_q    <= ifm_d;
        end
    end

    // Scratchpads carry no reset; contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (w_fire)  w_mem[KW'(w_cnt_q)]   <= io.w_wr_data;
        if (if_fire) if_mem[IW'(if_cnt_q)] <= io.if_wr_data;
    end

    assign io.w_wr_ready  = w_rdy_q;
    assign io.if_wr_ready = if_rdy_q;
    assign io.pe_en       = en_q;
    assign io.pe_op_valid = opv_q;
    assign io.pe_weight   = wt_q;
    assign io.pe_ifmap    = ifm_q;
    assign io.pe_win_idx  = win_q;
    assign io.busy        = busy_q;
    assign io.done        = done_q;
    assign io.err         = err_q;
endmodule

// File: tb/tb_pe_operand_feeder.sv
// Self-checking bench for pe_operand_feeder: vector table of start requests,
// a cycle-accurate window-schedule model, write stress and mid-run reset.
module tb_pe_operand_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    pe_operand_feeder_if #(.DATA_W(8)) io();

    pe_operand_feeder #(.DATA_W(8), .MAX_K(16), .MAX_IF(64)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int l;
        bit legal;
        int done_lat;
        bit fixed;
    } vec_t;

    vec_t tbl[8];
    logic [7:0] wts [16];
    logic [7:0] ifm [64];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " w_rdy"},  io.w_wr_ready,  0);
        check({tag, " if_rdy"}, io.if_wr_ready, 0);
        check({tag, " en"},     io.pe_en,       0);
        check({tag, " opv"},    io.pe_op_valid, 0);
        check({tag, " wt"},     io.pe_weight,   0);
        check({tag, " ifm"},    io.pe_ifmap,    0);
        check({tag, " win"},    io.pe_win_idx,  0);
        check({tag, " busy"},   io.busy,        0);
        check({tag, " done"},   io.done,        0);
        check({tag, " err"},    io.err,         0);
    endtask

    task automatic fill(input int k, input int l, input bit fixed);
        for (int j = 0; j < k; j++) wts[j] = fixed ? 8'(j + 1) : 8'($urandom);
        for (int i = 0; i < l; i++) ifm[i] = fixed ? 8'(10 + i) : 8'($urandom);
    endtask

    task automatic do_start(input int k, input int l);
        io.start       = 1'b1;
        io.kernel_size = 8'(k);
        io.ifmap_len   = 8'(l);
        tick();
        io.start = 1'b0;
    endtask

    // Writes both streams until ARM (first pe_en). stress: no gaps and three
    // extra weight words offered once the weight stream is full.
    task automatic load(input int k, input int l, input bit stress,
                        input int gap);
        int wi = 0, ii = 0, guard = 0, extra = 0;
        bit wv, iv;
        while (!io.pe_en && guard < 2000) begin
            check("w_wr_ready",  io.w_wr_ready,  wi < k);
            check("if_wr_ready", io.if_wr_ready, ii < l);
            if (wi < k) begin
                wv = stress || ($urandom_range(99) >= gap);
                io.w_wr_data = wts[wi];
            end else begin
                wv = stress && extra < 3;
                io.w_wr_data = 8'hEE;
                if (wv) extra++;
            end
            if (ii < l) begin
                iv = stress || ($urandom_range(99) >= gap);
                io.if_wr_data = ifm[ii];
            end else begin
                iv = 1'b0;
            end
            io.w_wr_valid  = wv;
            io.if_wr_valid = iv;
            if (wv && io.w_wr_ready)  wi++;
            if (iv && io.if_wr_ready) ii++;
            tick();
            guard++;
        end
        io.w_wr_valid  = 1'b0;
        io.if_wr_valid = 1'b0;
        check("load_reached_arm", guard < 2000, 1);
        check("load_w_count",  wi, k);
        check("load_if_count", ii, l);
        if (stress) begin
            check("load_cycles", guard, (k > l) ? k : l);
            check("extras_offered", extra, 3);
        end
    endtask

    // Called in the ARM cycle. Expected behaviour derives from the window
    // schedule: ARM, then N windows of IPSUM, K x OP, OPSUM, then done.
    // stop_at >= 0 ends early at that cycle offset (for the reset test).
    task automatic run_check(input int k, input int l, input int tbl_lat,
                             input int stop_at);
        int n = l - k + 1;
        int p = k + 2;
        int last = n * p + 1;
        int seen = -1;
        int ph, w;
        bit ev, ee;
        check("arm_en",   io.pe_en, 1);
        check("arm_opv",  io.pe_op_valid, 0);
        check("arm_busy", io.busy, 1);
        check("arm_win",  io.pe_win_idx, 0);
        for (int c = 1; c <= last; c++) begin
            tick();
            if (io.done && seen < 0) seen = c;
            if (c == last) begin
                check("end_done", io.done, 1);
                check("end_busy", io.busy, 0);
                check("end_en",   io.pe_en, 0);
                check("end_opv",  io.pe_op_valid, 0);
            end else begin
                ph = (c - 1) % p;
                w  = (c - 1) / p;
                ev = (ph >= 1) && (ph <= k);
                ee = (ph == k + 1) && (w < n - 1);
                check("run_opv",  io.pe_op_valid, ev);
                check("run_en",   io.pe_en, ee);
                check("run_busy", io.busy, 1);
                check("run_done", io.done, 0);
                if (ev) begin
                    check("pe_weight",  io.pe_weight, wts[ph-1]);
                    check("pe_ifmap",   io.pe_ifmap,  ifm[w+ph-1]);
                    check("pe_win_idx", io.pe_win_idx, w);
                end else begin
                    check("idle_weight", io.pe_weight, 0);
                    check("idle_ifmap",  io.pe_ifmap,  0);
                end
            end
            if (c == stop_at) return;
        end
        if (tbl_lat >= 0) check("done_latency", seen, tbl_lat);
        tick();
        check("done_pulse_end", io.done, 0);
        check("post_busy", io.busy, 0);
    endtask

    task automatic full_run(input int k, input int l, input bit fixed,
                            input bit stress, input int gap, input int lat);
        fill(k, l, fixed);
        do_start(k, l);
        check("start_busy", io.busy, 1);
        check("start_err",  io.err, 0);
        load(k, l, stress, gap);
        run_check(k, l, lat, -1);
    endtask

    initial begin
        tbl[0] = '{3,  5,  1, 16,  1};
        tbl[1] = '{1,  4,  1, 13,  0};
        tbl[2] = '{8,  8,  1, 11,  0};
        tbl[3] = '{0,  5,  0, 0,   0};
        tbl[4] = '{6,  5,  0, 0,   0};
        tbl[5] = '{17, 20, 0, 0,   0};
        tbl[6] = '{16, 64, 1, 883, 0};
        tbl[7] = '{2,  65, 0, 0,   0};

        io.start = 1'b0;
        io.kernel_size = 8'd0;
        io.ifmap_len = 8'd0;
        io.w_wr_valid = 1'b0;
        io.w_wr_data = 8'd0;
        io.if_wr_valid = 1'b0;
        io.if_wr_data = 8'd0;
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        foreach (tbl[v]) begin
            if (tbl[v].legal) begin
                full_run(tbl[v].k, tbl[v].l, tbl[v].fixed, 1'b0, 25,
                         tbl[v].done_lat);
            end else begin
                do_start(tbl[v].k, tbl[v].l);
                check("illegal_err",  io.err, 1);
                check("illegal_busy", io.busy, 0);
                check("illegal_rdy",  io.w_wr_ready, 0);
                tick();
                check("illegal_err_pulse", io.err, 0);
                check("illegal_busy2", io.busy, 0);
            end
            tick();
        end

        // Simultaneous writes plus refused extra weights.
        full_run(4, 8, 1'b0, 1'b1, 0, -1);
        tick();

        // Start while busy must be ignored: issue start in LOAD.
        fill(2, 3, 1'b0);
        do_start(2, 3);
        do_start(0, 0);
        check("start_in_load_err", io.err, 0);
        load(2, 3, 1'b0, 0);
        run_check(2, 3, 9, -1);
        tick();

        // Reset during OP of window 1, then a clean rerun.
        fill(3, 5, 1'b1);
        do_start(3, 5);
        load(3, 5, 1'b0, 20);
        run_check(3, 5, -1, 8);
        check("pre_reset_opv", io.pe_op_valid, 1);
        rst = 1'b1;
        tick();
        check_zero("midrst");
        rst = 1'b0;
        tick();
        check("midrst_busy", io.busy, 0);
        check("midrst_done", io.done, 0);
        check("midrst_err",  io.err, 0);
        full_run(3, 5, 1'b1, 1'b0, 0, 16);
        tick();

        for (int r = 0; r < 4; r++) begin
            int k, l;
            k = $urandom_range(16, 1);
            l = $urandom_range((k + 12 > 64) ? 64 : k + 12, k);
            full_run(k, l, 1'b0, 1'b0, 40, -1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
